// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, register constants and
// default datapath widths used by the ID/EX operand stage.
package cpu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  localparam int REG_X0 = 0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_ADDI  = 2'd3
  } aluop_e;

endpackage

// File: rtl/fwd_select.sv
// Priority operand mux for one source register: EX/MEM beats MEM/WB,
// and x0 always keeps the registered value.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    if (rs != REGW'(REG_X0)) begin
      if (mem_regwrite && (mem_rd == rs)) begin
        fwd_data = mem_result;
      end else if (wb_regwrite && (wb_rd == rs)) begin
        fwd_data = wb_result;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with capture-side write-back bypass, EX-side
// forwarding into the ALU operands and load-use stall detection.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alusrc,
  input  logic [1:0]      id_aluop,
  input  logic [3:0]      id_funct,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_regwrite,
  input  logic            flush,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [1:0]      ex_aluop,
  output logic [3:0]      ex_funct,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_regwrite
);

  logic [REGW-1:0] ex_rs1;
  logic [REGW-1:0] ex_rs2;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic            ex_alusrc;

  logic            load_en;
  logic [XLEN-1:0] cap_rs1_data;
  logic [XLEN-1:0] cap_rs2_data;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic            rs1_hit;
  logic            rs2_hit;

  // A load in EX cannot supply its value in time for a dependent instruction
  // in decode; rs2 only matters when it is actually read as an operand or stored.
  always_comb begin
    rs1_hit  = (ex_rd == id_rs1);
    rs2_hit  = (ex_rd == id_rs2) && (!id_alusrc || id_memwrite);
    stall_id = id_valid && ex_valid && ex_memread &&
               (ex_rd != REGW'(REG_X0)) && (rs1_hit || rs2_hit);
  end

  // The register file has no write-through, so a same-cycle write-back must
  // be picked up here or the stale read value would be latched.
  always_comb begin
    cap_rs1_data = id_rs1_data;
    cap_rs2_data = id_rs2_data;
    if (wb_regwrite && (wb_rd != REGW'(REG_X0)) && (wb_rd == id_rs1)) begin
      cap_rs1_data = wb_result;
    end
    if (wb_regwrite && (wb_rd != REGW'(REG_X0)) && (wb_rd == id_rs2)) begin
      cap_rs2_data = wb_result;
    end
  end

  assign load_en = id_valid && !flush && !stall_id;

  // Anything that is not a clean capture becomes an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_alusrc   <= 1'b0;
      ex_aluop    <= '0;
      ex_funct    <= '0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0;
    end else if (load_en) begin
      ex_valid    <= 1'b1;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1_data <= cap_rs1_data;
      ex_rs2_data <= cap_rs2_data;
      ex_imm      <= id_imm;
      ex_alusrc   <= id_alusrc;
      ex_aluop    <= id_aluop;
      ex_funct    <= id_funct;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_regwrite <= id_regwrite;
    end else begin
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_alusrc   <= 1'b0;
      ex_aluop    <= '0;
      ex_funct    <= '0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0;
    end
  end

  fwd_select #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .rs           (ex_rs1),
    .reg_data     (ex_rs1_data),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_result   (mem_result),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_result    (wb_result),
    .fwd_data     (fwd1)
  );

  fwd_select #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .rs           (ex_rs2),
    .reg_data     (ex_rs2_data),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_result   (mem_result),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_result    (wb_result),
    .fwd_data     (fwd2)
  );

  assign ex_a          = fwd1;
  assign ex_store_data = fwd2;
  assign ex_b          = ex_alusrc ? ex_imm : fwd2;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed hazard scenarios followed
// by random traffic, checked against an instruction-level model of the EX slot.
module tb_alu_operand_stage;

  typedef struct {
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic        memread, memwrite, regwrite;
    logic        flush;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_result;
  } stim_t;

  // Instruction sitting in EX, as the model understands it.
  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic        memread, memwrite, regwrite;
  } slot_t;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [31:0] a, b, sd;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [4:0]  rd;
    logic        mr, mw, rw;
  } exp_t;

  logic clk, rst_n;
  logic id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic id_alusrc;
  logic [1:0] id_aluop;
  logic [3:0] id_funct;
  logic id_memread, id_memwrite, id_regwrite, flush;
  logic [4:0] mem_rd, wb_rd;
  logic mem_regwrite, wb_regwrite;
  logic [31:0] mem_result, wb_result;
  logic stall_id, ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [1:0] ex_aluop;
  logic [3:0] ex_funct;
  logic [4:0] ex_rd;
  logic ex_memread, ex_memwrite, ex_regwrite;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_funct(id_funct),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_regwrite(id_regwrite),
    .flush(flush), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_aluop(ex_aluop), .ex_funct(ex_funct),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t  sb_q[$];
  slot_t model, model_next;
  int    vectors = 0;
  int    miscompares = 0;

  function automatic slot_t empty_slot();
    slot_t e;
    e = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, v1: 32'd0, v2: 32'd0,
          imm: 32'd0, alusrc: 1'b0, aluop: 2'd0, funct: 4'd0,
          memread: 1'b0, memwrite: 1'b0, regwrite: 1'b0};
    return e;
  endfunction

  function automatic stim_t blank();
    stim_t s;
    s = '{rst_n: 1'b1, id_valid: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          rs1_data: 32'd0, rs2_data: 32'd0, imm: 32'd0, alusrc: 1'b0,
          aluop: 2'd0, funct: 4'd0, memread: 1'b0, memwrite: 1'b0,
          regwrite: 1'b0, flush: 1'b0, mem_rd: 5'd0, mem_regwrite: 1'b0,
          mem_result: 32'd0, wb_rd: 5'd0, wb_regwrite: 1'b0, wb_result: 32'd0};
    return s;
  endfunction

  function automatic stim_t random_stim(input bit allow_reset);
    stim_t s;
    s = blank();
    s.rst_n        = allow_reset ? ($urandom_range(0, 59) != 0) : 1'b1;
    s.id_valid     = ($urandom_range(0, 9) < 8);
    s.rs1          = 5'($urandom_range(0, 7));
    s.rs2          = 5'($urandom_range(0, 7));
    s.rd           = 5'($urandom_range(0, 7));
    s.rs1_data     = $urandom;
    s.rs2_data     = $urandom;
    s.imm          = $urandom;
    s.alusrc       = 1'($urandom);
    s.aluop        = 2'($urandom);
    s.funct        = 4'($urandom);
    s.memread      = ($urandom_range(0, 9) < 3);
    s.memwrite     = 1'($urandom);
    s.regwrite     = 1'($urandom);
    s.flush        = ($urandom_range(0, 9) == 0);
    s.mem_rd       = 5'($urandom_range(0, 7));
    s.mem_regwrite = 1'($urandom);
    s.mem_result   = $urandom;
    s.wb_rd        = 5'($urandom_range(0, 7));
    s.wb_regwrite  = 1'($urandom);
    s.wb_result    = $urandom;
    return s;
  endfunction

  // Value a consumer of register r sees in EX: the youngest in-flight producer wins.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] held,
                                          input stim_t s);
    if (r == 5'd0) return held;
    if (s.mem_regwrite && s.mem_rd == r) return s.mem_result;
    if (s.wb_regwrite && s.wb_rd == r) return s.wb_result;
    return held;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle's inputs, predict this cycle's outputs and the next EX slot.
  task automatic driveVector(input stim_t s);
    exp_t e;
    bit   uses_rs2, dep;
    rst_n = s.rst_n; id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rd = s.rd; id_rs1_data = s.rs1_data; id_rs2_data = s.rs2_data;
    id_imm = s.imm; id_alusrc = s.alusrc; id_aluop = s.aluop; id_funct = s.funct;
    id_memread = s.memread; id_memwrite = s.memwrite; id_regwrite = s.regwrite;
    flush = s.flush; mem_rd = s.mem_rd; mem_regwrite = s.mem_regwrite;
    mem_result = s.mem_result; wb_rd = s.wb_rd; wb_regwrite = s.wb_regwrite;
    wb_result = s.wb_result;
    if (!s.rst_n) model = empty_slot();

    uses_rs2 = !s.alusrc || s.memwrite;
    dep = (model.rd == s.rs1) || (uses_rs2 && model.rd == s.rs2);
    e.stall = s.id_valid && model.valid && model.memread && model.rd != 5'd0 && dep;
    e.valid = model.valid;
    e.a     = operand(model.rs1, model.v1, s);
    e.sd    = operand(model.rs2, model.v2, s);
    e.b     = model.alusrc ? model.imm : e.sd;
    e.aluop = model.aluop;
    e.funct = model.funct;
    e.rd    = model.rd;
    e.mr    = model.memread;
    e.mw    = model.memwrite;
    e.rw    = model.regwrite;
    sb_q.push_back(e);

    model_next = empty_slot();
    if (s.rst_n && s.id_valid && !s.flush && !e.stall) begin
      model_next.valid    = 1'b1;
      model_next.rs1      = s.rs1;
      model_next.rs2      = s.rs2;
      model_next.rd       = s.rd;
      model_next.v1       = (s.wb_regwrite && s.wb_rd != 0 && s.wb_rd == s.rs1) ? s.wb_result : s.rs1_data;
      model_next.v2       = (s.wb_regwrite && s.wb_rd != 0 && s.wb_rd == s.rs2) ? s.wb_result : s.rs2_data;
      model_next.imm      = s.imm;
      model_next.alusrc   = s.alusrc;
      model_next.aluop    = s.aluop;
      model_next.funct    = s.funct;
      model_next.memread  = s.memread;
      model_next.memwrite = s.memwrite;
      model_next.regwrite = s.regwrite;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model = rst_n ? model_next : empty_slot();
    #1;
  endtask

  task automatic applyStimulus(input stim_t s);
    driveVector(s);
    advance();
  endtask

  // Monitor: one prediction per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      checkOutput("stall_id",      32'(stall_id),    32'(e.stall));
      checkOutput("ex_valid",      32'(ex_valid),    32'(e.valid));
      checkOutput("ex_a",          ex_a,             e.a);
      checkOutput("ex_b",          ex_b,             e.b);
      checkOutput("ex_store_data", ex_store_data,    e.sd);
      checkOutput("ex_aluop",      32'(ex_aluop),    32'(e.aluop));
      checkOutput("ex_funct",      32'(ex_funct),    32'(e.funct));
      checkOutput("ex_rd",         32'(ex_rd),       32'(e.rd));
      checkOutput("ex_memread",    32'(ex_memread),  32'(e.mr));
      checkOutput("ex_memwrite",   32'(ex_memwrite), 32'(e.mw));
      checkOutput("ex_regwrite",   32'(ex_regwrite), 32'(e.rw));
    end
  end

  initial begin
    stim_t s, lw;
    model = empty_slot();
    model_next = empty_slot();
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      s = random_stim(1'b0);
      s.rst_n = 1'b0;
      driveVector(s);
      #2;
      checkOutput("reset ex_valid", 32'(ex_valid), 32'd0);
      checkOutput("reset ex_a", ex_a, 32'd0);
      checkOutput("reset ex_regwrite", 32'(ex_regwrite), 32'd0);
      checkOutput("reset stall_id", 32'(stall_id), 32'd0);
      advance();
    end

    // add x3,x1,x2 with x1=5, x2=7.
    s = blank(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 2; s.rd = 3;
    s.rs1_data = 5; s.rs2_data = 7; s.aluop = 2; s.regwrite = 1;
    applyStimulus(s);
    driveVector(blank());
    #2;
    checkOutput("first add ex_a", ex_a, 32'd5);
    checkOutput("first add ex_b", ex_b, 32'd7);
    checkOutput("first add ex_aluop", 32'(ex_aluop), 32'd2);
    advance();

    // EX/MEM beats MEM/WB on the same register, then neither hits.
    s = blank(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 2; s.rd = 3;
    s.rs1_data = 32'h99; s.aluop = 2; s.regwrite = 1;
    applyStimulus(s);
    s = blank(); s.mem_rd = 1; s.mem_regwrite = 1; s.mem_result = 32'h10;
    s.wb_rd = 1; s.wb_regwrite = 1; s.wb_result = 32'h20;
    driveVector(s);
    #2;
    checkOutput("mem priority ex_a", ex_a, 32'h10);
    advance();
    s = blank(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 2; s.rd = 3;
    s.rs1_data = 32'h99; s.aluop = 2; s.regwrite = 1;
    applyStimulus(s);
    s = blank(); s.mem_regwrite = 1; s.mem_result = 32'h10;
    s.wb_regwrite = 1; s.wb_result = 32'h20;
    driveVector(s);
    #2;
    checkOutput("no fwd ex_a", ex_a, 32'h99);
    advance();

    // Load-use: lw x4 followed by add x5,x4,x6 stalls, addi x5,x6 does not.
    lw = blank(); lw.id_valid = 1; lw.rs1 = 1; lw.rd = 4; lw.alusrc = 1;
    lw.memread = 1; lw.regwrite = 1;
    applyStimulus(lw);
    s = blank(); s.id_valid = 1; s.rs1 = 4; s.rs2 = 6; s.rd = 5; s.aluop = 2; s.regwrite = 1;
    driveVector(s);
    #2;
    checkOutput("load-use stall_id", 32'(stall_id), 32'd1);
    advance();
    driveVector(blank());
    #2;
    checkOutput("load-use bubble ex_valid", 32'(ex_valid), 32'd0);
    advance();
    applyStimulus(lw);
    s = blank(); s.id_valid = 1; s.rs1 = 6; s.rs2 = 4; s.rd = 5; s.alusrc = 1;
    s.imm = 32'h3; s.aluop = 3; s.regwrite = 1;
    driveVector(s);
    #2;
    checkOutput("addi no stall", 32'(stall_id), 32'd0);
    advance();

    // Write-back bypass at capture.
    s = blank(); s.id_valid = 1; s.rs2 = 2; s.rs2_data = 0; s.rd = 9;
    s.wb_regwrite = 1; s.wb_rd = 2; s.wb_result = 32'hDEAD;
    applyStimulus(s);
    driveVector(blank());
    #2;
    checkOutput("capture bypass store", ex_store_data, 32'hDEAD);
    advance();

    // Flush wins over a load-use stall.
    applyStimulus(lw);
    s = blank(); s.id_valid = 1; s.rs1 = 4; s.rs2 = 6; s.rd = 5;
    s.regwrite = 1; s.memwrite = 1; s.flush = 1;
    applyStimulus(s);
    driveVector(blank());
    #2;
    checkOutput("flush ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("flush ex_regwrite", 32'(ex_regwrite), 32'd0);
    checkOutput("flush ex_memwrite", 32'(ex_memwrite), 32'd0);
    advance();

    // sw x7,8(x1) with x7 coming from EX/MEM.
    s = blank(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 7; s.rs1_data = 32'h100;
    s.imm = 8; s.alusrc = 1; s.memwrite = 1;
    applyStimulus(s);
    s = blank(); s.mem_rd = 7; s.mem_regwrite = 1; s.mem_result = 32'h55;
    driveVector(s);
    #2;
    checkOutput("store ex_b", ex_b, 32'd8);
    checkOutput("store ex_store_data", ex_store_data, 32'h55);
    checkOutput("store ex_memwrite", 32'(ex_memwrite), 32'd1);
    advance();

    // Random traffic with occasional mid-run resets.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(random_stim(1'b1));
    end
    applyStimulus(blank());

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
